// File: rtl/dvi_tmds_if.sv
// Pixel-side bus into the DVI TMDS encoder and the three 10-bit symbols it returns.
// The encoder takes the slave modport; the painting stage or a bench takes the master.
interface dvi_tmds_if #(
    parameter int BPC = 5
);
    logic           disp_hsync;
    logic           disp_vsync;
    logic           disp_de;
    logic [BPC-1:0] disp_r;
    logic [BPC-1:0] disp_g;
    logic [BPC-1:0] disp_b;
    logic [9:0]     tmds_r;
    logic [9:0]     tmds_g;
    logic [9:0]     tmds_b;

    modport master (
        output disp_hsync, disp_vsync, disp_de, disp_r, disp_g, disp_b,
        input  tmds_r, tmds_g, tmds_b
    );

    modport slave (
        input  disp_hsync, disp_vsync, disp_de, disp_r, disp_g, disp_b,
        output tmds_r, tmds_g, tmds_b
    );
endinterface

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder with a 2-stage pipeline.
// Stage 1 does the transition-minimising step; stage 2 does DC balancing and control tokens.
module dvi_tmds_encoder #(
    parameter int BPC = 5
) (
    input logic       clk_pix,
    input logic       rst_pix_n,
    dvi_tmds_if.slave bus
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Widen a BPC-bit channel to 8 bits by replicating its MSBs into the low bits.
    function automatic logic [7:0] widen(input logic [BPC-1:0] c);
        logic [7:0] v;
        v = 8'(c);
        return 8'((v << (8 - BPC)) | (v >> (2 * BPC - 8)));
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] min_transition(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            2'b11:   t = CTRL_11;
            default: t = CTRL_00;
        endcase
        return t;
    endfunction

    // Channel order in the packed vector: index 0 blue, 1 green, 2 red.
    logic [3*BPC-1:0] w_pix;
    assign w_pix = {bus.disp_r, bus.disp_g, bus.disp_b};

    logic r_de;
    logic r_hsync;
    logic r_vsync;

    // Stage 1: delay the shared timing signals alongside the per-channel q_m.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_de    <= 1'b0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_de    <= bus.disp_de;
            r_hsync <= bus.disp_hsync;
            r_vsync <= bus.disp_vsync;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [8:0]        r_qm;
        logic signed [5:0] r_cnt;
        logic [9:0]        r_tmds;
        logic [3:0]        w_n1;
        logic signed [5:0] w_diff;
        logic [1:0]        w_ctl;
        logic [9:0]        w_sym;
        logic signed [5:0] w_cnt_nxt;

        // Stage 1: transition-minimised word for this channel.
        always_ff @(posedge clk_pix or negedge rst_pix_n) begin
            if (!rst_pix_n) begin
                r_qm <= 9'd0;
            end else begin
                r_qm <= min_transition(widen(w_pix[ch*BPC +: BPC]));
            end
        end

        // w_diff is n1 - n0 of q_m[7:0], i.e. 2*n1 - 8.
        assign w_n1   = popcount8(r_qm[7:0]);
        assign w_diff = $signed({1'b0, w_n1, 1'b0}) - 6'sd8;
        assign w_ctl  = (ch == 0) ? {r_vsync, r_hsync} : 2'b00;

        // Stage 2 next-state: DC-balanced data symbol or control token.
        always_comb begin
            w_sym     = CTRL_00;
            w_cnt_nxt = 6'sd0;
            if (r_de) begin
                if ((r_cnt == 6'sd0) || (w_diff == 6'sd0)) begin
                    if (r_qm[8]) begin
                        w_sym     = {2'b01, r_qm[7:0]};
                        w_cnt_nxt = r_cnt + w_diff;
                    end else begin
                        w_sym     = {2'b10, ~r_qm[7:0]};
                        w_cnt_nxt = r_cnt - w_diff;
                    end
                end else if ((!r_cnt[5] && (w_diff > 6'sd0)) || (r_cnt[5] && (w_diff < 6'sd0))) begin
                    w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
                    w_cnt_nxt = r_cnt + (r_qm[8] ? 6'sd2 : 6'sd0) - w_diff;
                end else begin
                    w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
                    w_cnt_nxt = r_cnt + w_diff - (r_qm[8] ? 6'sd0 : 6'sd2);
                end
            end else begin
                w_sym     = ctrl_token(w_ctl);
                w_cnt_nxt = 6'sd0;
            end
        end

        // Stage 2: registered symbol and running disparity.
        always_ff @(posedge clk_pix or negedge rst_pix_n) begin
            if (!rst_pix_n) begin
                r_tmds <= CTRL_00;
                r_cnt  <= 6'sd0;
            end else begin
                r_tmds <= w_sym;
                r_cnt  <= w_cnt_nxt;
            end
        end
    end

    assign bus.tmds_b = g_ch[0].r_tmds;
    assign bus.tmds_g = g_ch[1].r_tmds;
    assign bus.tmds_r = g_ch[2].r_tmds;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: directed token/disparity cases plus random frames,
// checked every cycle against an integer TMDS encode/decode model.
module tb_dvi_tmds_encoder;

    localparam int BPC = 5;
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic clk_pix   = 1'b0;
    logic rst_pix_n = 1'b0;
    always #5 clk_pix = ~clk_pix;

    dvi_tmds_if #(.BPC(BPC)) bus ();
    dvi_tmds_encoder #(.BPC(BPC)) dut (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic              de;
        logic              hs;
        logic              vs;
        logic [BPC-1:0]    r;
        logic [BPC-1:0]    g;
        logic [BPC-1:0]    b;
        logic              lit;
        logic [9:0]        lr;
        logic [9:0]        lg;
        logic [9:0]        lb;
        logic              lce;
        logic signed [7:0] lcnt;
    } slot_t;

    slot_t cur = '0;
    slot_t p1;
    slot_t p2;

    assign bus.disp_de    = cur.de;
    assign bus.disp_hsync = cur.hs;
    assign bus.disp_vsync = cur.vs;
    assign bus.disp_r     = cur.r;
    assign bus.disp_g     = cur.g;
    assign bus.disp_b     = cur.b;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int ones(input int v, input int nb);
        int n = 0;
        for (int i = 0; i < nb; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic int widen(input int c);
        return ((c << (8 - BPC)) | (c >> (2 * BPC - 8))) & 255;
    endfunction

    // Reference encoder: pick the cheaper-transition code, then invert if that helps balance.
    function automatic int encode(input int d, input int cnt_in, output int cnt_out);
        int  n   = ones(d, 8);
        bit  xn  = (n > 4) || (n == 4 && (d & 1) == 0);
        int  qm  = d & 1;
        int  q8  = xn ? 0 : 1;
        int  bal;
        int  sym;
        for (int i = 1; i < 8; i++) begin
            int b = ((qm >> (i - 1)) & 1) ^ ((d >> i) & 1);
            if (xn) b = 1 - b;
            qm |= b << i;
        end
        bal = 2 * ones(qm, 8) - 8;
        if (cnt_in == 0 || bal == 0)
            sym = q8 ? ((1 << 8) | qm) : ((1 << 9) | (~qm & 255));
        else if ((cnt_in > 0 && bal > 0) || (cnt_in < 0 && bal < 0))
            sym = (1 << 9) | (q8 << 8) | (~qm & 255);
        else
            sym = (q8 << 8) | qm;
        cnt_out = cnt_in + 2 * ones(sym, 10) - 10;
        return sym;
    endfunction

    function automatic int decode(input int sym);
        int d   = sym & 255;
        int out;
        if ((sym >> 9) & 1) d = ~d & 255;
        out = d & 1;
        for (int i = 1; i < 8; i++) begin
            int b = ((d >> i) & 1) ^ ((d >> (i - 1)) & 1);
            if (((sym >> 8) & 1) == 0) b = 1 - b;
            out |= b << i;
        end
        return out;
    endfunction

    // Track which input slot is due at the outputs (two edges after capture).
    always @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p2 <= p1;
            p1 <= cur;
        end
    end

    int mcnt[3];
    int dcnt[3];

    // Compare outputs against the model on every falling edge.
    always @(negedge clk_pix) begin
        logic [9:0] act[3];
        logic [9:0] lit[3];
        int         pix;
        int         exp;
        int         nc;
        slot_t      s;
        act[0] = bus.tmds_b;
        act[1] = bus.tmds_g;
        act[2] = bus.tmds_r;
        s      = p2;
        lit[0] = s.lb;
        lit[1] = s.lg;
        lit[2] = s.lr;
        for (int ch = 0; ch < 3; ch++) begin
            if (!rst_pix_n) begin
                mcnt[ch] = 0;
                dcnt[ch] = 0;
                check("reset_sym", int'(act[ch]), int'(TOK0));
            end else begin
                pix = (ch == 0) ? int'(s.b) : (ch == 1) ? int'(s.g) : int'(s.r);
                if (s.de) begin
                    exp      = encode(widen(pix), mcnt[ch], nc);
                    mcnt[ch] = nc;
                    dcnt[ch] += 2 * ones(int'(act[ch]), 10) - 10;
                    check("disparity_range", int'(dcnt[ch] >= -10 && dcnt[ch] <= 10), 1);
                    check("decode", decode(int'(act[ch])), widen(pix));
                    if (s.lce) check("literal_cnt", dcnt[ch], int'($signed(s.lcnt)));
                end else begin
                    exp      = (ch == 0) ? int'(s.vs ? (s.hs ? TOK3 : TOK2) : (s.hs ? TOK1 : TOK0))
                                         : int'(TOK0);
                    mcnt[ch] = 0;
                    dcnt[ch] = 0;
                end
                check("model_sym", int'(act[ch]), exp);
                if (s.lit) check("literal_sym", int'(act[ch]), int'(lit[ch]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [BPC-1:0] r, input logic [BPC-1:0] g, input logic [BPC-1:0] b,
                         input logic lt, input logic [9:0] lr, input logic [9:0] lg, input logic [9:0] lb,
                         input logic ce, input int lc);
        cur.de   = de;
        cur.hs   = hs;
        cur.vs   = vs;
        cur.r    = r;
        cur.g    = g;
        cur.b    = b;
        cur.lit  = lt;
        cur.lr   = lr;
        cur.lg   = lg;
        cur.lb   = lb;
        cur.lce  = ce;
        cur.lcnt = 8'(lc);
        tick();
    endtask

    task automatic drive_rand(input logic de);
        drive(de, 1'($urandom), 1'($urandom), BPC'($urandom), BPC'($urandom), BPC'($urandom),
              1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 0);
    endtask

    initial begin
        int  c;
        int  cyc;
        int  run;
        bit  did_reset;
        localparam logic [BPC-1:0] Z = '0;
        localparam logic [BPC-1:0] W = '1;

        // Pin the model itself against hand-computed symbols.
        check("model_pin_black", encode(0, 0, c), int'(10'b0100000000));
        check("model_pin_black_cnt", c, -8);
        check("model_pin_white", encode(255, 0, c), int'(10'b1000000000));
        check("model_pin_white_cnt", c, -8);
        check("model_pin_widen", widen(31), 255);
        check("model_pin_decode", decode(int'(10'b1111111111)), 0);

        repeat (6) drive_rand(1'($urandom));
        rst_pix_n = 1'b1;

        repeat (3) drive(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, TOK0, TOK0, TOK0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, Z, Z, Z, 1'b1, TOK0, TOK0, TOK1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, Z, Z, Z, 1'b1, TOK0, TOK0, TOK3, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1, Z, Z, Z, 1'b1, TOK0, TOK0, TOK2, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, TOK0, TOK0, TOK0, 1'b0, 0);

        drive(1'b1, 1'b0, 1'b0, Z, Z, Z, 1'b1, 10'b0100000000, 10'b0100000000, 10'b0100000000, 1'b1, -8);
        drive(1'b1, 1'b0, 1'b0, Z, Z, Z, 1'b1, 10'b1111111111, 10'b1111111111, 10'b1111111111, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, Z, Z, Z, 1'b1, 10'b0100000000, 10'b0100000000, 10'b0100000000, 1'b1, -6);
        drive(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, TOK0, TOK0, TOK0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, Z, Z, Z, 1'b1, 10'b0100000000, 10'b0100000000, 10'b0100000000, 1'b1, -8);
        drive(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, TOK0, TOK0, TOK0, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, W, W, W, 1'b1, 10'b1000000000, 10'b1000000000, 10'b1000000000, 1'b1, -8);
        drive(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, TOK0, TOK0, TOK0, 1'b0, 0);

        cyc       = 0;
        did_reset = 1'b0;
        while (cyc < 30000) begin
            run = $urandom_range(1, 80);
            for (int i = 0; i < run; i++) begin
                drive_rand(1'b1);
                cyc++;
                // One reset in the middle of an active run.
                if (!did_reset && cyc > 15000 && i == run / 2) begin
                    did_reset = 1'b1;
                    #2 rst_pix_n = 1'b0;
                    drive_rand(1'b1);
                    drive_rand(1'b1);
                    rst_pix_n = 1'b1;
                end
            end
            run = $urandom_range(1, 6);
            for (int i = 0; i < run; i++) begin
                drive_rand(1'b0);
                cyc++;
            end
        end

        repeat (4) drive(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b0, TOK0, TOK0, TOK0, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
